// File: rtl/isp_pkg.sv
// Shared ISP definitions: colour codes, strip geometry and RGB payload helpers.
package isp_pkg;

  localparam int unsigned STRIP_ROWS = 6;
  localparam int unsigned STRIP_STEP = 4;
  localparam int unsigned SAMPLE_W   = 8;

  typedef enum logic [2:0] {
    COLOR_RED   = 3'd0,
    COLOR_GREEN = 3'd1,
    COLOR_BLUE  = 3'd2,
    COLOR_VOID  = 3'd3
  } color_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] r;
    logic [SAMPLE_W-1:0] g;
    logic [SAMPLE_W-1:0] b;
  } rgb_t;

  // Selects one colour sample of a pixel; VOID yields zero.
  function automatic logic [SAMPLE_W-1:0] color_sample(input rgb_t px, input color_e c);
    case (c)
      COLOR_RED:   return px.r;
      COLOR_GREEN: return px.g;
      COLOR_BLUE:  return px.b;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/pixel_scan_ctr.sv
// Strip scan position (row-in-strip, column, strip base row) and frame-buffer address.
module pixel_scan_ctr
  import isp_pkg::*;
#(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 18,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last_col,
  output logic              exhausted
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned SUB_W = 3;
  localparam logic [ROW_W-1:0] LAST_R0 = ROW_W'(IMG_H - STRIP_ROWS);

  logic [SUB_W-1:0] sub_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] r0_q;
  logic             exh_q;
  logic             sub_wrap;
  logic             final_px;

  assign sub_wrap  = (sub_q == SUB_W'(STRIP_ROWS - 1));
  assign last_col  = (col_q == COL_W'(IMG_W - 1));
  assign final_px  = sub_wrap && last_col && (r0_q == LAST_R0);
  assign exhausted = exh_q;
  assign addr      = ADDR_W'((ADDR_W'(r0_q) + ADDR_W'(sub_q)) * ADDR_W'(IMG_W)) + ADDR_W'(col_q);

  // Advance row within column, then column, then strip; flag once the final pixel is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q <= '0;
      col_q <= '0;
      r0_q  <= '0;
      exh_q <= 1'b0;
    end else if (clr) begin
      sub_q <= '0;
      col_q <= '0;
      r0_q  <= '0;
      exh_q <= 1'b0;
    end else if (adv && !exh_q) begin
      if (final_px) begin
        exh_q <= 1'b1;
      end else if (!sub_wrap) begin
        sub_q <= sub_q + SUB_W'(1);
      end else begin
        sub_q <= '0;
        if (!last_col) begin
          col_q <= col_q + COL_W'(1);
        end else begin
          col_q <= '0;
          r0_q  <= r0_q + ROW_W'(STRIP_STEP);
        end
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Streams a frame buffer as overlapping 6-row strips, one R/G/B beat per cycle.
// Optional build macro PIXEL_TX_GAP_EN adds gap_len VOID cycles after each B beat.
module pixel_stream_tx
  import isp_pkg::*;
#(
  parameter int unsigned IMG_W  = 16,
  parameter int unsigned IMG_H  = 18,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef PIXEL_TX_GAP_EN
  input  logic [3:0]        gap_len,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        pixel_out,
  output logic              valid_out,
  output logic [2:0]        color_out,
  output logic              last_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned GAP_W = 4;
  localparam int unsigned OFF_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    DONE  = 3'd3
`ifdef PIXEL_TX_GAP_EN
    , GAP = 3'd4
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  color_e            color_q, color_d;
  logic              rd_en_d, valid_d, last_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic              issue_rd;

  logic [GAP_W-1:0]  gap_q;
  logic              rd_d1;
  logic              rd_last_q;
  rgb_t              hold_q;
  logic              hold_last;

  logic [ADDR_W-1:0] scan_addr;
  logic              scan_last_col;
  logic              scan_exh;
  logic              scan_clr;

  pixel_scan_ctr #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clr       (scan_clr),
    .adv       (issue_rd),
    .addr      (scan_addr),
    .last_col  (scan_last_col),
    .exhausted (scan_exh)
  );

  assign color_out = color_q;
  assign pixel_out = color_sample(hold_q, color_q);

`ifdef PIXEL_TX_GAP_EN
  // Gap length is fixed for the whole frame at the accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        gap_q <= '0;
    else if (state_q == IDLE && start) gap_q <= gap_len;
  end
`else
  assign gap_q = '0;
`endif

  // Read-return pipeline: capture pixel data and its last-column tag one cycle after the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_d1     <= 1'b0;
      rd_last_q <= 1'b0;
      hold_q    <= '0;
      hold_last <= 1'b0;
    end else begin
      rd_d1 <= mem_rd_en;
      if (issue_rd) rd_last_q <= scan_last_col;
      if (rd_d1) begin
        hold_q    <= rgb_t'(mem_rdata);
        hold_last <= rd_last_q;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      off_q     <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      valid_out <= 1'b0;
      color_q   <= COLOR_VOID;
      last_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
      valid_out <= valid_d;
      color_q   <= color_d;
      last_out  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // off_q counts cycles since the current R beat; next read lands gap cycles after the G beat.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    rd_en_d  = 1'b0;
    addr_d   = mem_addr;
    valid_d  = 1'b0;
    color_d  = COLOR_VOID;
    last_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    scan_clr = 1'b0;
    issue_rd = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = FETCH;
          off_d    = '0;
          issue_rd = 1'b1;
          busy_d   = 1'b1;
        end
      end
      FETCH: begin
        if (off_q == '0) begin
          off_d = OFF_W'(1);
        end else begin
          state_d = EMIT;
          off_d   = '0;
          valid_d = 1'b1;
          color_d = COLOR_RED;
          last_d  = rd_last_q;
        end
      end
`ifdef PIXEL_TX_GAP_EN
      EMIT, GAP: begin
`else
      EMIT: begin
`endif
        if (off_q == OFF_W'(gap_q) && !scan_exh) issue_rd = 1'b1;
        if (off_q == OFF_W'(gap_q) + OFF_W'(2)) begin
          // A read issued last cycle means another pixel follows.
          if (rd_d1) begin
            state_d = EMIT;
            off_d   = '0;
            valid_d = 1'b1;
            color_d = COLOR_RED;
            last_d  = rd_last_q;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          off_d = off_q + OFF_W'(1);
          if (off_q == OFF_W'(0)) begin
            state_d = EMIT;
            valid_d = 1'b1;
            color_d = COLOR_GREEN;
            last_d  = hold_last;
          end else if (off_q == OFF_W'(1)) begin
            state_d = EMIT;
            valid_d = 1'b1;
            color_d = COLOR_BLUE;
            last_d  = hold_last;
          end else begin
`ifdef PIXEL_TX_GAP_EN
            state_d = GAP;
`else
            state_d = EMIT;
`endif
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        scan_clr = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue_rd) begin
      rd_en_d = 1'b1;
      addr_d  = scan_addr;
    end
  end

endmodule
